trail_stack: RTL and testbench

Parametrised assignment trail for the DPLL solver, replacing the fixed-size trace stack. It records every variable assignment as a decision or forced entry and tracks the current decision level. Given a single `backtrack_start` pulse from control, it runs the whole conflict backtrack itself: it unwinds forced entries, flips the nearest decision in place, and streams unassign and flip events to the var_state write port.

---
 rtl/trail_stack.sv | 170 +++++++++++++++++
 tb/tb_trail_stack.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/trail_stack.sv
// Assignment trail for the DPLL solver: push/pop of decision/forced entries,
// decision-level tracking, and a self-running conflict backtrack that streams var_state events.
module trail_stack #(
  parameter int DEPTH    = 256,
  parameter int VAR_BITS = 8,
  parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic [VAR_BITS-1:0] var_in,
  input  logic                val_in,
  input  logic                type_in,
  input  logic                pop,
  input  logic                backtrack_start,
  output logic [VAR_BITS-1:0] var_out,
  output logic                val_out,
  output logic                type_out,
  output logic                empty,
  output logic                full,
  output logic [CNT_BITS-1:0] count,
  output logic [CNT_BITS-1:0] level,
  output logic                busy,
  output logic                unassign_valid,
  output logic                flip_valid,
  output logic [VAR_BITS-1:0] ev_var,
  output logic                ev_val,
  output logic                bt_done,
  output logic                bt_unsat,
  output logic                overflow
);
  localparam int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W   = VAR_BITS + 2;

  typedef enum logic {S_IDLE, S_BT} state_t;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic [CNT_BITS-1:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  unassign_q, unassign_d;
  logic                  flip_q, flip_d;
  logic                  done_q, done_d;
  logic                  unsat_q, unsat_d;
  logic [VAR_BITS-1:0]   ev_var_q, ev_var_d;
  logic                  ev_val_q, ev_val_d;

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic                  wr_en;
  logic [ADDR_BITS-1:0]  wr_idx;
  logic [ENTRY_W-1:0]    wr_data;

  logic [ADDR_BITS-1:0]  top_idx;
  logic [ENTRY_W-1:0]    top_entry;
  logic                  empty_w, full_w;

  assign empty_w   = (count_q == '0);
  assign full_w    = (count_q == CNT_BITS'(DEPTH));
  assign top_idx   = ADDR_BITS'(count_q - CNT_BITS'(1));
  assign top_entry = empty_w ? '0 : mem_q[top_idx];

  assign var_out        = top_entry[ENTRY_W-1:2];
  assign val_out        = top_entry[1];
  assign type_out       = top_entry[0];
  assign empty          = empty_w;
  assign full           = full_w;
  assign count          = count_q;
  assign level          = level_q;
  assign busy           = (state_q == S_BT);
  assign unassign_valid = unassign_q;
  assign flip_valid     = flip_q;
  assign bt_done        = done_q;
  assign bt_unsat       = unsat_q;
  assign ev_var         = ev_var_q;
  assign ev_val         = ev_val_q;
  assign overflow       = overflow_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    unassign_d = 1'b0;
    flip_d     = 1'b0;
    done_d     = 1'b0;
    unsat_d    = 1'b0;
    ev_var_d   = '0;
    ev_val_d   = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = top_idx;
    wr_data    = {var_in, val_in, type_in};

    unique case (state_q)
      S_IDLE: begin
        if (backtrack_start) begin
          if (empty_w) unsat_d = 1'b1;
          else         state_d = S_BT;
        end else if (push && pop && !empty_w) begin
          wr_en   = 1'b1;
          level_d = level_q + CNT_BITS'(!type_in) - CNT_BITS'(!type_out);
        end else if (push) begin
          if (full_w) begin
            overflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = ADDR_BITS'(count_q);
            count_d = count_q + CNT_BITS'(1);
            level_d = level_q + CNT_BITS'(!type_in);
          end
        end else if (pop && !empty_w) begin
          count_d = count_q - CNT_BITS'(1);
          level_d = level_q - CNT_BITS'(!type_out);
        end
      end
      S_BT: begin
        if (empty_w) begin
          unsat_d = 1'b1;
          state_d = S_IDLE;
        end else if (type_out) begin
          count_d    = count_q - CNT_BITS'(1);
          unassign_d = 1'b1;
          ev_var_d   = var_out;
        end else begin
          // Nearest decision is flipped in place and becomes a forced entry.
          wr_en    = 1'b1;
          wr_data  = {var_out, ~val_out, 1'b1};
          level_d  = level_q - CNT_BITS'(1);
          flip_d   = 1'b1;
          done_d   = 1'b1;
          ev_var_d = var_out;
          ev_val_d = ~val_out;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      unassign_q <= 1'b0;
      flip_q     <= 1'b0;
      done_q     <= 1'b0;
      unsat_q    <= 1'b0;
      ev_var_q   <= '0;
      ev_val_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      unassign_q <= unassign_d;
      flip_q     <= flip_d;
      done_q     <= done_d;
      unsat_q    <= unsat_d;
      ev_var_q   <= ev_var_d;
      ev_val_q   <= ev_val_d;
    end
  end

  // Entry storage needs no reset: everything above count is don't-care.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem_q[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_trail_stack.sv
// Directed bench for trail_stack (DEPTH=4): expected per-cycle event vectors are queued
// before each backtrack and popped/compared as the DUT runs.
module tb_trail_stack;
  logic       clock = 1'b0;
  logic       reset, push, val_in, type_in, pop, backtrack_start;
  logic [7:0] var_in, var_out, ev_var;
  logic       val_out, type_out, empty, full, busy;
  logic       unassign_valid, flip_valid, ev_val, bt_done, bt_unsat, overflow;
  logic [2:0] count, level;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

  trail_stack #(.DEPTH(4), .VAR_BITS(8)) dut (
    .clock(clock), .reset(reset), .push(push), .var_in(var_in), .val_in(val_in),
    .type_in(type_in), .pop(pop), .backtrack_start(backtrack_start),
    .var_out(var_out), .val_out(val_out), .type_out(type_out), .empty(empty),
    .full(full), .count(count), .level(level), .busy(busy),
    .unassign_valid(unassign_valid), .flip_valid(flip_valid), .ev_var(ev_var),
    .ev_val(ev_val), .bt_done(bt_done), .bt_unsat(bt_unsat), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] ev(input logic b, input logic u, input logic f,
                                     input logic d, input logic s,
                                     input logic [7:0] v, input logic vl);
    return {b, u, f, d, s, v, vl};
  endfunction

  function automatic logic [12:0] obs_ev();
    return {busy, unassign_valid, flip_valid, bt_done, bt_unsat, ev_var, ev_val};
  endfunction

  task automatic do_op(input logic ps, input logic pp, input logic [7:0] v,
                       input logic vl, input logic ty);
    push = ps; pop = pp; var_in = v; val_in = vl; type_in = ty;
    tick();
    push = 1'b0; pop = 1'b0; var_in = '0; val_in = 1'b0; type_in = 1'b0;
  endtask

  // {count, level, empty, full, overflow, var_out, val_out, type_out}
  task automatic check_stk(input string tag, input logic [2:0] c, input logic [2:0] l,
                           input logic ov, input logic [7:0] v, input logic vl,
                           input logic ty);
    check(tag, {count, level, empty, full, overflow, var_out, val_out, type_out},
          {c, l, (c == 3'd0), (c == 3'd4), ov, v, vl, ty});
  endtask

  // Pulses backtrack_start (optionally with a simultaneous push), then drains the queue
  // one cycle per entry; with interfere set, push+pop are held high while busy.
  task automatic run_bt(input string tag, input logic interfere, input logic with_push);
    backtrack_start = 1'b1;
    if (with_push) begin
      push = 1'b1; var_in = 8'h55; val_in = 1'b1; type_in = 1'b0;
    end
    tick();
    backtrack_start = 1'b0; push = 1'b0; var_in = '0; val_in = 1'b0; type_in = 1'b0;
    while (exp_q.size() > 0) begin
      check(tag, obs_ev(), exp_q.pop_front());
      if (exp_q.size() > 0) begin
        push = interfere && busy; pop = interfere && busy;
        var_in = 8'hEE; type_in = 1'b0;
        tick();
      end
    end
    push = 1'b0; pop = 1'b0; var_in = '0; type_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b1; pop = 1'b1; backtrack_start = 1'b1;
    var_in = 8'hAA; val_in = 1'b1; type_in = 1'b0;
    tick(); tick();
    check_stk("reset_stack", 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_events", obs_ev(), 13'h0);
    reset = 1'b0; push = 1'b0; pop = 1'b0; backtrack_start = 1'b0;
    var_in = '0; val_in = 1'b0; type_in = 1'b0;
    tick();

    // Basic backtrack: D(5,1) F(9,0) F(3,1) F(7,0)
    do_op(1, 0, 8'd5, 1, 0);
    do_op(1, 0, 8'd9, 0, 1);
    do_op(1, 0, 8'd3, 1, 1);
    do_op(1, 0, 8'd7, 0, 1);
    check_stk("basic_pushed", 3'd4, 3'd1, 1'b0, 8'd7, 1'b0, 1'b1);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 8'd0, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd7, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd3, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd9, 0));
    exp_q.push_back(ev(0, 0, 1, 1, 0, 8'd5, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 8'd0, 0));
    run_bt("basic_bt", 1'b0, 1'b0);
    check_stk("basic_after", 3'd1, 3'd0, 1'b0, 8'd5, 1'b0, 1'b1);

    // UNSAT with forced-only trail
    do_op(0, 1, 8'd0, 0, 0);
    check_stk("pop_to_empty", 3'd0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    do_op(1, 0, 8'd2, 1, 1);
    do_op(1, 0, 8'd4, 0, 1);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 8'd0, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd4, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd2, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 1, 8'd0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 8'd0, 0));
    run_bt("unsat_bt", 1'b0, 1'b0);
    check_stk("unsat_after", 3'd0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Backtrack on empty trail
    exp_q.push_back(ev(0, 0, 0, 0, 1, 8'd0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 8'd0, 0));
    run_bt("empty_bt", 1'b0, 1'b0);

    // Nested levels, first backtrack with push/pop interference
    do_op(1, 0, 8'd1, 0, 0);
    do_op(1, 0, 8'd2, 1, 1);
    do_op(1, 0, 8'd3, 1, 0);
    do_op(1, 0, 8'd4, 1, 1);
    check_stk("nested_pushed", 3'd4, 3'd2, 1'b0, 8'd4, 1'b1, 1'b1);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 8'd0, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd4, 0));
    exp_q.push_back(ev(0, 0, 1, 1, 0, 8'd3, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 8'd0, 0));
    run_bt("nested_bt1", 1'b1, 1'b0);
    check_stk("nested_after1", 3'd3, 3'd1, 1'b0, 8'd3, 1'b0, 1'b1);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 8'd0, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd3, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd2, 0));
    exp_q.push_back(ev(0, 0, 1, 1, 0, 8'd1, 1));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 8'd0, 0));
    run_bt("nested_bt2", 1'b0, 1'b0);
    check_stk("nested_after2", 3'd1, 3'd0, 1'b0, 8'd1, 1'b1, 1'b1);

    // backtrack_start together with push: the push (decision 0x55) must be dropped
    exp_q.push_back(ev(1, 0, 0, 0, 0, 8'd0, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd1, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 1, 8'd0, 0));
    run_bt("start_push_bt", 1'b0, 1'b1);
    check_stk("start_push_after", 3'd0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Full / overflow / replace / pop-on-empty
    do_op(1, 0, 8'd10, 1, 0);
    do_op(1, 0, 8'd11, 0, 1);
    do_op(1, 0, 8'd12, 1, 1);
    check_stk("fill_3", 3'd3, 3'd1, 1'b0, 8'd12, 1'b1, 1'b1);
    do_op(1, 0, 8'd13, 0, 1);
    check_stk("fill_4_full", 3'd4, 3'd1, 1'b0, 8'd13, 1'b0, 1'b1);
    do_op(1, 0, 8'd14, 1, 1);
    check_stk("overflow_drop", 3'd4, 3'd1, 1'b1, 8'd13, 1'b0, 1'b1);
    do_op(1, 1, 8'd20, 1, 0);
    check_stk("replace_top", 3'd4, 3'd2, 1'b1, 8'd20, 1'b1, 1'b0);
    do_op(0, 1, 8'd0, 0, 0);
    check_stk("pop_decision", 3'd3, 3'd1, 1'b1, 8'd12, 1'b1, 1'b1);
    do_op(0, 1, 8'd0, 0, 0);
    do_op(0, 1, 8'd0, 0, 0);
    check_stk("pop_to_decision", 3'd1, 3'd1, 1'b1, 8'd10, 1'b1, 1'b0);
    do_op(0, 1, 8'd0, 0, 0);
    do_op(0, 1, 8'd0, 0, 0);
    check_stk("pop_on_empty", 3'd0, 3'd0, 1'b1, 8'd0, 1'b0, 1'b0);
    do_op(1, 1, 8'd30, 1, 1);
    check_stk("pushpop_empty", 3'd1, 3'd0, 1'b1, 8'd30, 1'b1, 1'b1);

    // Reset right after the 2nd unassign event
    do_op(1, 0, 8'd40, 1, 0);
    do_op(1, 0, 8'd41, 0, 1);
    do_op(1, 0, 8'd42, 1, 1);
    exp_q.push_back(ev(1, 0, 0, 0, 0, 8'd0, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd42, 0));
    exp_q.push_back(ev(1, 1, 0, 0, 0, 8'd41, 0));
    run_bt("midbt", 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_stk("midbt_reset", 3'd0, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("midbt_reset_ev", obs_ev(), 13'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midbt_quiet", {obs_ev(), count}, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
